ddr3_line_cache: RTL and testbench

Direct-mapped, write-back line cache between the CPU/bus word port and `ddr3_ctrl`. It serves 32-bit word reads and writes with byte enables from a small register-based line store. Misses are turned into 256-bit line transfers on `ddr3_ctrl`'s `rd_i`/`we_i`/`ack_o` request port. Everything runs in the system `clk` domain; `ddr3_ctrl` handles the crossing into `ui_clk`.

---
 rtl/ddr3_line_cache.sv | 153 +++++++++++++++
 tb/tb_ddr3_line_cache.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_line_cache.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_line_cache
// Purpose  : Direct-mapped write-back cache of 256-bit lines between a 32-bit
//            CPU word port and the ddr3_ctrl line request port.
// Revision : 1.0 - initial release
// ============================================================================
module ddr3_line_cache #(
  parameter int LINES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [28:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  input  logic [3:0]   cpu_sel_i,
  input  logic         cpu_we_i,
  input  logic         cpu_rd_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_ack_o,
  output logic [28:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  output logic         mem_we_o,
  output logic         mem_rd_o,
  input  logic         mem_ack_i,
  output logic [2:0]   state_o
);

  localparam int IDX  = $clog2(LINES);
  localparam int TAGW = 29 - 5 - IDX;

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_IDLE = 3'd1,
    S_WB   = 3'd2,
    S_FILL = 3'd3,
    S_ACK  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [LINES-1:0] r_valid;
  logic [LINES-1:0] r_dirty;
  logic [TAGW-1:0]  r_tag  [LINES];
  logic [255:0]     r_line [LINES];

  logic [IDX-1:0]  w_idx;
  logic [TAGW-1:0] w_tag;
  logic [2:0]      w_word;
  logic            w_req;
  logic            w_hit;
  logic            w_victim_dirty;
  logic [31:0]     w_rd_word;
  logic            w_unused_addr;

  assign w_idx          = cpu_addr_i[5+IDX-1:5];
  assign w_tag          = cpu_addr_i[28:5+IDX];
  assign w_word         = cpu_addr_i[4:2];
  assign w_req          = cpu_we_i | cpu_rd_i;
  assign w_hit          = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_victim_dirty = r_valid[w_idx] & r_dirty[w_idx];
  assign w_rd_word      = r_line[w_idx][32*int'(w_word) +: 32];
  assign w_unused_addr  = ^cpu_addr_i[1:0];

  assign cpu_ack_o = (r_state == S_ACK);
  assign state_o   = r_state;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_INIT;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT: if (mem_ack_i) w_next = S_IDLE;
      S_IDLE: begin
        if (w_req) begin
          if (w_hit)               w_next = S_ACK;
          else if (w_victim_dirty) w_next = S_WB;
          else                     w_next = S_FILL;
        end
      end
      S_WB:   if (mem_ack_i) w_next = S_FILL;
      S_FILL: if (mem_ack_i) w_next = S_IDLE;
      S_ACK:  w_next = S_IDLE;
      default: w_next = S_INIT;
    endcase
  end

  // Line store and memory-side registers; the address is held by the CPU
  // for the whole miss, so w_idx/w_tag stay valid through WB and FILL.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= '0;
      r_dirty    <= '0;
      cpu_data_o <= '0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
      mem_we_o   <= 1'b0;
      mem_rd_o   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (w_hit) begin
              if (cpu_we_i) begin
                for (int b = 0; b < 4; b++) begin
                  if (cpu_sel_i[b])
                    r_line[w_idx][32*int'(w_word) + 8*b +: 8] <= cpu_data_i[8*b +: 8];
                end
                r_dirty[w_idx] <= 1'b1;
              end else begin
                cpu_data_o <= w_rd_word;
              end
            end else if (w_victim_dirty) begin
              mem_addr_o <= {r_tag[w_idx], w_idx, 5'b0};
              mem_data_o <= r_line[w_idx];
              mem_we_o   <= 1'b1;
            end else begin
              mem_addr_o <= {w_tag, w_idx, 5'b0};
              mem_rd_o   <= 1'b1;
            end
          end
        end
        S_WB: begin
          if (mem_ack_i) begin
            r_dirty[w_idx] <= 1'b0;
            mem_we_o       <= 1'b0;
            mem_addr_o     <= {w_tag, w_idx, 5'b0};
          end
        end
        S_FILL: begin
          // Coming from WB the request stays low for one cycle so ddr3_ctrl
          // sees a fresh rising edge.
          if (mem_ack_i) begin
            r_line[w_idx]  <= mem_data_i;
            r_tag[w_idx]   <= w_tag;
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= 1'b0;
            mem_rd_o       <= 1'b0;
          end else if (!mem_rd_o) begin
            mem_rd_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ddr3_line_cache.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr3_line_cache
// Purpose  : Directed self-checking bench for ddr3_line_cache (LINES=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr3_line_cache;

  logic         clk = 1'b0;
  logic         rst;
  logic [28:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic [3:0]   cpu_sel_i;
  logic         cpu_we_i;
  logic         cpu_rd_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_ack_o;
  logic [28:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_we_o;
  logic         mem_rd_o;
  logic         mem_ack_i;
  logic [2:0]   state_o;

  ddr3_line_cache #(.LINES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_addr_i (cpu_addr_i),
    .cpu_data_i (cpu_data_i),
    .cpu_sel_i  (cpu_sel_i),
    .cpu_we_i   (cpu_we_i),
    .cpu_rd_i   (cpu_rd_i),
    .cpu_data_o (cpu_data_o),
    .cpu_ack_o  (cpu_ack_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_o (mem_data_o),
    .mem_data_i (mem_data_i),
    .mem_we_o   (mem_we_o),
    .mem_rd_o   (mem_rd_o),
    .mem_ack_i  (mem_ack_i),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int overlap = 0;

  always @(negedge clk) if (mem_we_o && mem_rd_o) overlap++;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] mk_line(input logic [31:0] base);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[32*w +: 32] = base + 32'(w);
    return l;
  endfunction

  // Entered at a negedge; ack is high across exactly one rising edge.
  task automatic pulse_ack(input logic [255:0] line);
    mem_data_i = line;
    mem_ack_i  = 1'b1;
    @(negedge clk);
    mem_ack_i  = 1'b0;
  endtask

  task automatic cpu_access(input logic we, input logic rd, input logic [28:0] addr,
                            input logic [31:0] d, input logic [3:0] sel,
                            output logic [31:0] q, output int lat, output bit mem);
    @(negedge clk);
    cpu_we_i = we; cpu_rd_i = rd; cpu_addr_i = addr; cpu_data_i = d; cpu_sel_i = sel;
    lat = 0; mem = 1'b0; q = 'x;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      mem = mem | mem_rd_o | mem_we_o;
      if (cpu_ack_o) begin
        q = cpu_data_o;
        break;
      end
    end
    cpu_we_i = 1'b0; cpu_rd_i = 1'b0;
  endtask

  logic [255:0] l0, l1, l2, exp_line;
  logic [31:0]  q;
  int           lat;
  bit           mem, any_ack, any_rd, stable;

  initial begin
    rst = 1'b1; cpu_addr_i = '0; cpu_data_i = '0; cpu_sel_i = '0;
    cpu_we_i = 1'b0; cpu_rd_i = 1'b0; mem_data_i = '0; mem_ack_i = 1'b0;
    l0 = mk_line(32'h1000_0000); l0[63:32] = 32'hDEADBEEF;
    l1 = mk_line(32'h2000_0000);
    l2 = mk_line(32'h3000_0000);
    repeat (3) @(negedge clk);
    chk("rst_state", state_o, 3'd0);
    chk("rst_ack", cpu_ack_o, 1'b0);
    chk("rst_cpu_data", cpu_data_o, 32'h0);
    chk("rst_mem_req", {mem_we_o, mem_rd_o}, 2'b00);
    chk("rst_mem_addr", mem_addr_o, 29'h0);
    chk("rst_mem_data", mem_data_o, 256'h0);
    rst = 1'b0;

    // 1: init hold-off
    cpu_rd_i = 1'b1; cpu_addr_i = 29'h044;
    any_ack = 1'b0; any_rd = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      any_ack |= cpu_ack_o;
      any_rd  |= mem_rd_o;
    end
    chk("init_no_ack", any_ack, 1'b0);
    chk("init_no_rd", any_rd, 1'b0);
    chk("init_state", state_o, 3'd0);
    pulse_ack('0);
    chk("calib_idle", state_o, 3'd1);
    @(negedge clk);
    chk("miss_rd", mem_rd_o, 1'b1);
    chk("miss_addr", mem_addr_o, 29'h040);
    chk("miss_state", state_o, 3'd3);

    // 2: clean miss completes, then hit
    pulse_ack(l0);
    chk("fill_rd_drop", mem_rd_o, 1'b0);
    chk("fill_no_early_ack", cpu_ack_o, 1'b0);
    @(negedge clk);
    chk("fill_ack", cpu_ack_o, 1'b1);
    chk("fill_data", cpu_data_o, 32'hDEADBEEF);
    cpu_rd_i = 1'b0;
    cpu_access(1'b0, 1'b1, 29'h048, '0, 4'h0, q, lat, mem);
    chk("hit_data", q, 32'h1000_0002);
    chk("hit_lat", lat, 1);
    chk("hit_no_mem", mem, 1'b0);

    // 3: byte-enable write hit
    cpu_access(1'b1, 1'b0, 29'h044, 32'h11223344, 4'b0011, q, lat, mem);
    chk("wr_lat", lat, 1);
    chk("wr_no_mem", mem, 1'b0);
    cpu_access(1'b0, 1'b1, 29'h044, '0, 4'h0, q, lat, mem);
    chk("wr_readback", q, 32'hDEAD3344);

    // 4 + 5a: dirty eviction with slow memory
    @(negedge clk);
    cpu_rd_i = 1'b1; cpu_addr_i = 29'h0C4;
    @(negedge clk);
    exp_line = l0; exp_line[63:32] = 32'hDEAD3344;
    chk("wb_we", {mem_we_o, mem_rd_o}, 2'b10);
    chk("wb_addr", mem_addr_o, 29'h040);
    chk("wb_word1", mem_data_o[63:32], 32'hDEAD3344);
    chk("wb_line", mem_data_o, exp_line);
    stable = 1'b1; any_ack = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mem_addr_o !== 29'h040 || mem_data_o !== exp_line || mem_we_o !== 1'b1) stable = 1'b0;
      any_ack |= cpu_ack_o;
    end
    chk("slow_stable", stable, 1'b1);
    chk("slow_no_ack", any_ack, 1'b0);
    pulse_ack('0);
    chk("wb_gap_req", {mem_we_o, mem_rd_o}, 2'b00);
    chk("wb_gap_state", state_o, 3'd3);
    @(negedge clk);
    chk("evict_rd", mem_rd_o, 1'b1);
    chk("evict_addr", mem_addr_o, 29'h0C0);
    pulse_ack(l1);
    @(negedge clk);
    chk("evict_ack", cpu_ack_o, 1'b1);
    chk("evict_data", cpu_data_o, 32'h2000_0001);
    cpu_rd_i = 1'b0;

    // 5b: rd+we collision executes as a write
    cpu_access(1'b1, 1'b1, 29'h0C8, 32'hCAFEF00D, 4'hF, q, lat, mem);
    chk("coll_lat", lat, 1);
    chk("coll_no_mem", mem, 1'b0);
    cpu_access(1'b0, 1'b1, 29'h0C8, '0, 4'h0, q, lat, mem);
    chk("coll_readback", q, 32'hCAFEF00D);
    @(negedge clk);
    cpu_rd_i = 1'b1; cpu_addr_i = 29'h048;
    @(negedge clk);
    exp_line = l1; exp_line[95:64] = 32'hCAFEF00D;
    chk("coll_dirty_we", mem_we_o, 1'b1);
    chk("coll_wb_addr", mem_addr_o, 29'h0C0);
    chk("coll_wb_line", mem_data_o, exp_line);
    pulse_ack('0);
    @(negedge clk);
    chk("refill_rd", mem_rd_o, 1'b1);
    chk("refill_addr", mem_addr_o, 29'h040);

    // 6: reset mid-fill
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_rd", mem_rd_o, 1'b0);
    chk("midrst_state", state_o, 3'd0);
    chk("midrst_addr", mem_addr_o, 29'h0);
    chk("midrst_data", mem_data_o, 256'h0);
    rst = 1'b0; cpu_rd_i = 1'b0;
    pulse_ack('0);
    chk("recal_idle", state_o, 3'd1);
    @(negedge clk);
    cpu_rd_i = 1'b1; cpu_addr_i = 29'h0C8;
    @(negedge clk);
    chk("inval_miss_rd", {mem_we_o, mem_rd_o}, 2'b01);
    chk("inval_miss_addr", mem_addr_o, 29'h0C0);
    pulse_ack(l2);
    @(negedge clk);
    chk("inval_ack", cpu_ack_o, 1'b1);
    chk("inval_data", cpu_data_o, 32'h3000_0002);
    cpu_rd_i = 1'b0;
    repeat (2) @(negedge clk);

    chk("no_rd_we_overlap", overlap, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
